freq_multi_scan: RTL and testbench
==================================

// Module: freq_multi_scan
// PURPOSE
//  Reader/checker on the result side of freq_multi_count, in the refclk domain.
//  Watches source_state. Each time a channel's measurement is committed to the
//  counter RAM, it reads that channel from every bank over addr/frequency.
//  Each fresh result is checked against programmable lo/hi limits, cached
//  locally for host readout, and raises sticky per-channel alarms.
// PARAMETERS
//  NF   8   channels per counter block (must match freq_multi_count)
//  NG   1   counter blocks (must match freq_multi_count)
//  cw   3   macro-cycle counter width in source_state
//  uw   28  frequency result width
//  NA_  $clog2(NF)  derived, do not override
//  NB_  $clog2(NG)  derived, do not override
//  NCH = NF*NG total channels; channel index = {bank, chan}
// PORTS
//  refclk        in   1          sole clock (same refclk as the counter)
//  rst_n         in   1          asynchronous active-low reset
//  source_state  in   NA_+cw     from freq_multi_count
//  addr          out  NB_+NA_    to freq_multi_count addr (registered)
//  frequency     in   uw         from freq_multi_count, valid 1 cycle after addr
//  lim_we        in   1          limit write strobe
//  lim_sel       in   1          0 = lo limit, 1 = hi limit
//  lim_addr      in   NB_+NA_    channel for limit write
//  lim_data      in   uw         limit value
//  rd_addr       in   NB_+NA_    host cache read channel
//  rd_data       out  uw+3       {fresh, too_high, too_low, freq}, 1 cycle after rd_addr
//  res_valid     out  1          one-cycle pulse per checked result
//  res_chan      out  NB_+NA_    channel of res_freq
//  res_freq      out  uw         checked result
//  alarm         out  NCH        sticky out-of-range flags
//  alarm_clr     in   NCH        per-bit alarm clear strobe
//  alarm_any     out  1          OR of alarm (registered)
//  overrun       out  1          sticky: update arrived while two already pending
// BEHAVIOUR
//  Reset: addr=0, res_valid=0, res_chan=0, res_freq=0, alarm=0, alarm_any=0,
//   overrun=0, rd_data=0, all cache fresh/flag bits 0, lo=0, hi=all-ones.
//   ss_d is loaded from source_state on the first clock after reset.
//   First event after reset is discarded (arm flag).
//  Event detection: ss_d <= source_state every cycle. An event is source_state != ss_d.
//   The just-completed channel is p = ss_d[NA_-1:0].
//  FSM IDLE/WAIT/CAP, bank index g:
//   IDLE, event (armed): addr<={0,p}, g<=0 -> WAIT.
//   WAIT: one cycle for the counter RAM read -> CAP.
//   CAP: sample frequency and compare, update cache, pulse res_valid next cycle.
//    If g<NG-1: addr<={g+1,p}, g<=g+1 -> WAIT. Else -> IDLE, or straight to the pending scan.
//  Latency: event in cycle E gives res_valid in cycle E+3+2g for bank g.
//   Scan takes 2*NG+1 cycles.
//  Pending: an event arriving when not IDLE stores p in a 1-deep pending register.
//   An event with the pending register already full sets overrun; the newest p wins.
//  Compare (unsigned, uw bits): too_low = f<lo, too_high = f>hi. f==lo or f==hi is in range.
//   If lo>hi, both flags may be set; no special-casing.
//  Cache entry write: {1, too_high, too_low, f}. fresh stays 1 until reset.
//  alarm[c]: set when a checked result for c is out of range; cleared by alarm_clr[c].
//   If set and clear occur in the same cycle, set wins.
//  Limits: lim_we writes lo or hi for lim_addr at the clock edge.
//   A CAP in the same cycle uses the old limit value.
//  Cache read: rd_data <= cache[rd_addr]. A same-cycle cache write returns the old entry.
//  Reset mid-scan: FSM->IDLE, pending cleared, re-armed (next event discarded).
//  NG=1: bank field is zero-width; addr=p.
// TESTING
//  1 Reset, then step source_state 0->1: no res_valid (arm discard).
//    Step 1->2: addr=1 at E+1, res_valid at E+3, res_chan=1.
//  2 lo[3]=1000, hi[3]=2000, event for ch3 with frequency=999: too_low and alarm[3] set.
//    Repeat with 1000 and 2000: no new alarm. 2001: too_high.
//  3 alarm[3] set, alarm_clr[3] pulsed in the same cycle as a new out-of-range CAP:
//    alarm[3] stays 1. Clear alone: alarm[3]=0 and alarm_any=0 next cycle.
//  4 NG=2, event for p=5: addr sequence 5 then 13, res_valid at E+3 and E+5,
//    rd_data(13) fresh=1.
//  5 Three events 1 cycle apart during a scan: second scanned right after the first,
//    third replaces pending, overrun=1.
//  6 rst_n low during WAIT, release: outputs at reset values, next event discarded,
//    following event scanned normally.

Source files
------------

// File: rtl/freq_multi_scan_if.sv
// freq_multi_scan_if
//   Bundles every non-clock signal of freq_multi_scan.
//   slave  : the scanner side (consumes source_state/frequency/host controls,
//            produces addr, cache readout, results and alarms)
//   master : the counter/host side (the mirror image)
//   Widths follow the scanner parameters: channel index = {bank, chan}.
interface freq_multi_scan_if #(
    parameter int NF = 8,
    parameter int NG = 1,
    parameter int cw = 3,
    parameter int uw = 28
);
    localparam int NA_ = $clog2(NF);
    localparam int NB_ = $clog2(NG);
    localparam int CW  = NB_ + NA_;
    localparam int NCH = NF * NG;

    logic [NA_+cw-1:0] source_state;
    logic [CW-1:0]     addr;
    logic [uw-1:0]     frequency;
    logic              lim_we;
    logic              lim_sel;
    logic [CW-1:0]     lim_addr;
    logic [uw-1:0]     lim_data;
    logic [CW-1:0]     rd_addr;
    logic [uw+2:0]     rd_data;
    logic              res_valid;
    logic [CW-1:0]     res_chan;
    logic [uw-1:0]     res_freq;
    logic [NCH-1:0]    alarm;
    logic [NCH-1:0]    alarm_clr;
    logic              alarm_any;
    logic              overrun;

    modport slave (
        input  source_state, frequency, lim_we, lim_sel, lim_addr, lim_data,
               rd_addr, alarm_clr,
        output addr, rd_data, res_valid, res_chan, res_freq, alarm, alarm_any,
               overrun
    );

    modport master (
        output source_state, frequency, lim_we, lim_sel, lim_addr, lim_data,
               rd_addr, alarm_clr,
        input  addr, rd_data, res_valid, res_chan, res_freq, alarm, alarm_any,
               overrun
    );
endinterface

// File: rtl/freq_multi_scan.sv
// freq_multi_scan
//   Result-side reader/checker for freq_multi_count (refclk domain).
//   Every change of source_state marks the channel in its low bits as freshly
//   committed; that channel is then read from every counter bank, checked
//   against per-channel lo/hi limits, cached for the host and flagged in
//   sticky alarms.
// Ports
//   refclk : sole clock
//   rst_n  : asynchronous active-low reset
//   bus    : freq_multi_scan_if.slave (counter addr/frequency, limit writes,
//            host cache read, result stream, alarms, overrun)
module freq_multi_scan #(
    parameter int NF = 8,
    parameter int NG = 1,
    parameter int cw = 3,
    parameter int uw = 28
) (
    input  logic             refclk,
    input  logic             rst_n,
    freq_multi_scan_if.slave bus
);
    localparam int NA_ = $clog2(NF);
    localparam int NB_ = $clog2(NG);
    localparam int CW  = NB_ + NA_;
    localparam int GW  = (NB_ > 0) ? NB_ : 1;  // bank counter needs >= 1 bit
    localparam int NCH = NF * NG;
    localparam int SW  = NA_ + cw;

    typedef enum logic [1:0] {IDLE, WAIT, CAP} state_t;

    state_t          state_q;
    logic [SW-1:0]   ss_q;        // delayed source_state
    logic            ss_vld_q;    // ss_q holds a real sample (not reset value)
    logic            armed_q;     // first event after reset is dropped
    logic [GW-1:0]   g_q;         // bank being scanned
    logic [NA_-1:0]  p_q;         // channel being scanned
    logic            pend_vld_q;
    logic [NA_-1:0]  pend_p_q;
    logic [CW-1:0]   addr_q;
    logic            res_valid_q;
    logic [CW-1:0]   res_chan_q;
    logic [uw-1:0]   res_freq_q;
    logic [NCH-1:0]  alarm_q;
    logic [NCH-1:0]  alarm_d;
    logic            alarm_any_q;
    logic            overrun_q;
    logic [uw+2:0]   rd_data_q;
    logic [uw-1:0]   lo_q    [NCH];
    logic [uw-1:0]   hi_q    [NCH];
    logic [uw+2:0]   cache_q [NCH];

    logic            ev;
    logic            ev_ok;
    logic [NA_-1:0]  ev_p;
    logic            too_lo;
    logic            too_hi;
    logic            last_bank;
    logic [NCH-1:0]  set_vec;

    // Channel index {bank, chan} as a number.
    function automatic logic [CW-1:0] chan_of(input logic [GW-1:0] g,
                                              input logic [NA_-1:0] p);
        return CW'(int'(g) * NF + int'(p));
    endfunction

    assign ev        = ss_vld_q && (bus.source_state != ss_q);
    assign ev_ok     = ev && armed_q;
    assign ev_p      = ss_q[NA_-1:0];
    // In CAP, addr_q is the channel whose data is on frequency.
    assign too_lo    = bus.frequency < lo_q[addr_q];
    assign too_hi    = bus.frequency > hi_q[addr_q];
    assign last_bank = !(int'(g_q) < NG - 1);

    always_comb begin
        set_vec = '0;
        if (state_q == CAP && (too_lo || too_hi))
            set_vec[addr_q] = 1'b1;
        // set applied after clear so a simultaneous set wins
        alarm_d = (alarm_q & ~bus.alarm_clr) | set_vec;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_q        <= '0;
            ss_vld_q    <= 1'b0;
            armed_q     <= 1'b0;
            g_q         <= '0;
            p_q         <= '0;
            pend_vld_q  <= 1'b0;
            pend_p_q    <= '0;
            addr_q      <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_freq_q  <= '0;
            alarm_q     <= '0;
            alarm_any_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                lo_q[i]    <= '0;
                hi_q[i]    <= '1;
                cache_q[i] <= '0;
            end
        end else begin
            ss_q        <= bus.source_state;
            ss_vld_q    <= 1'b1;
            res_valid_q <= 1'b0;
            alarm_q     <= alarm_d;
            alarm_any_q <= |alarm_d;
            rd_data_q   <= cache_q[bus.rd_addr];

            if (ev)
                armed_q <= 1'b1;

            if (bus.lim_we) begin
                if (bus.lim_sel) hi_q[bus.lim_addr] <= bus.lim_data;
                else             lo_q[bus.lim_addr] <= bus.lim_data;
            end

            // Events while busy go to the 1-deep pending slot; newest wins.
            // Overrun looks at the registered slot, so an event landing on
            // the CAP that pops the slot still counts as an overrun.
            if (state_q != IDLE && ev_ok) begin
                pend_p_q   <= ev_p;
                pend_vld_q <= 1'b1;
                if (pend_vld_q)
                    overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ev_ok) begin
                        p_q     <= ev_p;
                        g_q     <= '0;
                        addr_q  <= chan_of('0, ev_p);
                        state_q <= WAIT;
                    end
                end
                WAIT: state_q <= CAP;
                CAP: begin
                    res_valid_q      <= 1'b1;
                    res_chan_q       <= addr_q;
                    res_freq_q       <= bus.frequency;
                    cache_q[addr_q]  <= {1'b1, too_hi, too_lo, bus.frequency};
                    if (!last_bank) begin
                        g_q     <= g_q + GW'(1);
                        addr_q  <= chan_of(g_q + GW'(1), p_q);
                        state_q <= WAIT;
                    end else if (pend_vld_q) begin
                        p_q     <= pend_p_q;
                        g_q     <= '0;
                        addr_q  <= chan_of('0, pend_p_q);
                        state_q <= WAIT;
                        if (!ev_ok)
                            pend_vld_q <= 1'b0;
                    end else if (ev_ok) begin
                        // slot was empty: start the new event directly
                        p_q        <= ev_p;
                        g_q        <= '0;
                        addr_q     <= chan_of('0, ev_p);
                        state_q    <= WAIT;
                        pend_vld_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addr      = addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_chan  = res_chan_q;
    assign bus.res_freq  = res_freq_q;
    assign bus.alarm     = alarm_q;
    assign bus.alarm_any = alarm_any_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_freq_multi_scan.sv
// Directed bench: d1 is the default NF=8/NG=1 scanner, d2 a two-bank
// variant. A registered RAM model per DUT plays the counter's addr/frequency.
module tb_freq_multi_scan;
    logic refclk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;
    logic [2:0] m1 = '0;

    logic [27:0] mem1 [8];
    logic [27:0] mem2 [16];

    always #5 refclk = ~refclk;

    freq_multi_scan_if #(.NF(8), .NG(1), .cw(3), .uw(28)) i1 ();
    freq_multi_scan_if #(.NF(8), .NG(2), .cw(3), .uw(28)) i2 ();

    freq_multi_scan #(.NF(8), .NG(1), .cw(3), .uw(28)) d1 (
        .refclk(refclk), .rst_n(rst_n), .bus(i1));
    freq_multi_scan #(.NF(8), .NG(2), .cw(3), .uw(28)) d2 (
        .refclk(refclk), .rst_n(rst_n), .bus(i2));

    // counter RAM: data valid one cycle after addr
    always @(posedge refclk) begin
        i1.frequency <= mem1[i1.addr];
        i2.frequency <= mem2[i2.addr];
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Park low bits at p (scans whatever was there), let it drain, then
    // change only the macro bits: event for channel p in the current cycle.
    task automatic ev1(input logic [2:0] p);
        m1 = m1 + 3'd1;
        i1.source_state = {m1, p};
        repeat (6) tick();
        m1 = m1 + 3'd1;
        i1.source_state = {m1, p};
    endtask

    task automatic set_lim(input logic sel, input logic [2:0] a, input logic [27:0] d);
        i1.lim_we = 1'b1; i1.lim_sel = sel; i1.lim_addr = a; i1.lim_data = d;
        tick();
        i1.lim_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i1.source_state = '0; i1.lim_we = 0; i1.lim_sel = 0; i1.lim_addr = '0;
        i1.lim_data = '0; i1.rd_addr = '0; i1.alarm_clr = '0;
        i2.source_state = '0; i2.lim_we = 0; i2.lim_sel = 0; i2.lim_addr = '0;
        i2.lim_data = '0; i2.rd_addr = '0; i2.alarm_clr = '0;
        for (int i = 0; i < 8; i++) mem1[i] = '0;
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        repeat (2) tick();
        vecs++; if (i1.addr !== 3'd0 || i1.res_valid !== 1'b0 || i1.res_chan !== 3'd0
                    || i1.res_freq !== 28'd0) begin
            errs++; $display("FAIL reset_res addr=%0h rv=%0b ch=%0h f=%0h want 0",
                             i1.addr, i1.res_valid, i1.res_chan, i1.res_freq);
        end
        vecs++; if (i1.alarm !== 8'h00 || i1.alarm_any !== 1'b0 || i1.overrun !== 1'b0
                    || i1.rd_data !== 31'd0) begin
            errs++; $display("FAIL reset_flags alarm=%0h any=%0b ovr=%0b rd=%0h want 0",
                             i1.alarm, i1.alarm_any, i1.overrun, i1.rd_data);
        end
        vecs++; if (i2.addr !== 4'd0 || i2.res_valid !== 1'b0) begin
            errs++; $display("FAIL reset_ng2 addr=%0h rv=%0b want 0", i2.addr, i2.res_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arm();
        logic seen;
        mem1[1] = 28'd12345;
        tick();
        i1.source_state = 6'd1;          // first event: discarded
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (i1.res_valid !== 1'b0 || i1.addr !== 3'd0) seen = 1'b1;
        end
        vecs++; if (seen) begin
            errs++; $display("FAIL arm_discard saw activity, want none");
        end
        i1.source_state = 6'd2;          // cycle E, p=1
        tick();
        vecs++; if (i1.addr !== 3'd1 || i1.res_valid !== 1'b0) begin
            errs++; $display("FAIL arm_e1 addr=%0h rv=%0b want 1/0", i1.addr, i1.res_valid);
        end
        tick();
        vecs++; if (i1.res_valid !== 1'b0) begin
            errs++; $display("FAIL arm_e2 rv=%0b want 0", i1.res_valid);
        end
        tick();
        vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd1 || i1.res_freq !== 28'd12345) begin
            errs++; $display("FAIL arm_e3 rv=%0b ch=%0h f=%0d want 1/1/12345",
                             i1.res_valid, i1.res_chan, i1.res_freq);
        end
        tick();
        vecs++; if (i1.res_valid !== 1'b0) begin
            errs++; $display("FAIL arm_pulse rv=%0b want 0", i1.res_valid);
        end
    endtask

    task automatic test_limits();
        logic [27:0] fv [4] = '{28'd999, 28'd1000, 28'd2000, 28'd2001};
        logic [2:0]  fl [4] = '{3'b101, 3'b100, 3'b100, 3'b110};
        logic        al [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_lim(1'b0, 3'd3, 28'd1000);
        set_lim(1'b1, 3'd3, 28'd2000);
        i1.rd_addr = 3'd3;
        for (int k = 0; k < 4; k++) begin
            i1.alarm_clr = 8'hff;
            tick();
            i1.alarm_clr = 8'h00;
            mem1[3] = fv[k];
            ev1(3'd3);
            repeat (3) tick();
            vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd3 || i1.res_freq !== fv[k]) begin
                errs++; $display("FAIL lim_res[%0d] rv=%0b ch=%0h f=%0d want 1/3/%0d",
                                 k, i1.res_valid, i1.res_chan, i1.res_freq, fv[k]);
            end
            vecs++; if (i1.alarm[3] !== al[k] || i1.alarm_any !== al[k]) begin
                errs++; $display("FAIL lim_alarm[%0d] alarm3=%0b any=%0b want %0b",
                                 k, i1.alarm[3], i1.alarm_any, al[k]);
            end
            tick();
            vecs++; if (i1.rd_data !== {fl[k], fv[k]}) begin
                errs++; $display("FAIL lim_cache[%0d] rd=%0h want %0h", k, i1.rd_data, {fl[k], fv[k]});
            end
        end
    endtask

    task automatic test_alarm_clr();
        // alarm[3] is set, mem1[3]=2001 still too high
        ev1(3'd3);
        tick();
        tick();                          // E+2: CAP
        i1.alarm_clr = 8'h08;
        tick();
        i1.alarm_clr = 8'h00;
        vecs++; if (i1.alarm[3] !== 1'b1 || i1.res_valid !== 1'b1) begin
            errs++; $display("FAIL clr_vs_set alarm3=%0b rv=%0b want 1/1", i1.alarm[3], i1.res_valid);
        end
        i1.alarm_clr = 8'h08;
        tick();
        i1.alarm_clr = 8'h00;
        vecs++; if (i1.alarm !== 8'h00 || i1.alarm_any !== 1'b0) begin
            errs++; $display("FAIL clr_alone alarm=%0h any=%0b want 0/0", i1.alarm, i1.alarm_any);
        end
    endtask

    task automatic test_limit_race();
        mem1[3] = 28'd1500;
        ev1(3'd3);
        tick();
        tick();                          // E+2: CAP, lo write lands same edge
        i1.lim_we = 1'b1; i1.lim_sel = 1'b0; i1.lim_addr = 3'd3; i1.lim_data = 28'd1600;
        tick();
        i1.lim_we = 1'b0;
        vecs++; if (i1.res_valid !== 1'b1 || i1.alarm[3] !== 1'b0) begin
            errs++; $display("FAIL lim_race_old rv=%0b alarm3=%0b want 1/0", i1.res_valid, i1.alarm[3]);
        end
        ev1(3'd3);
        repeat (3) tick();
        vecs++; if (i1.alarm[3] !== 1'b1) begin
            errs++; $display("FAIL lim_race_new alarm3=%0b want 1", i1.alarm[3]);
        end
        tick();
        vecs++; if (i1.rd_data !== {3'b101, 28'd1500}) begin
            errs++; $display("FAIL lim_race_cache rd=%0h want %0h", i1.rd_data, {3'b101, 28'd1500});
        end
        i1.alarm_clr = 8'hff;
        tick();
        i1.alarm_clr = 8'h00;
    endtask

    task automatic test_ng2();
        mem2[5]  = 28'd111;
        mem2[13] = 28'd222;
        i2.source_state = 6'd5;          // first event: discarded
        repeat (4) tick();
        i2.source_state = 6'd6;          // cycle E, p=5
        tick();
        vecs++; if (i2.addr !== 4'd5) begin
            errs++; $display("FAIL ng2_addr0 addr=%0d want 5", i2.addr);
        end
        tick();
        vecs++; if (i2.res_valid !== 1'b0) begin
            errs++; $display("FAIL ng2_e2 rv=%0b want 0", i2.res_valid);
        end
        tick();
        vecs++; if (i2.addr !== 4'd13 || i2.res_valid !== 1'b1 || i2.res_chan !== 4'd5
                    || i2.res_freq !== 28'd111) begin
            errs++; $display("FAIL ng2_e3 addr=%0d rv=%0b ch=%0d f=%0d want 13/1/5/111",
                             i2.addr, i2.res_valid, i2.res_chan, i2.res_freq);
        end
        tick();
        vecs++; if (i2.res_valid !== 1'b0) begin
            errs++; $display("FAIL ng2_e4 rv=%0b want 0", i2.res_valid);
        end
        tick();
        vecs++; if (i2.res_valid !== 1'b1 || i2.res_chan !== 4'd13 || i2.res_freq !== 28'd222) begin
            errs++; $display("FAIL ng2_e5 rv=%0b ch=%0d f=%0d want 1/13/222",
                             i2.res_valid, i2.res_chan, i2.res_freq);
        end
        i2.rd_addr = 4'd13;
        tick();
        vecs++; if (i2.rd_data !== {3'b100, 28'd222}) begin
            errs++; $display("FAIL ng2_cache rd=%0h want %0h", i2.rd_data, {3'b100, 28'd222});
        end
    endtask

    task automatic test_back_to_back();
        mem1[4] = 28'd44; mem1[5] = 28'd55; mem1[6] = 28'd66;
        m1 = m1 + 3'd1;
        i1.source_state = {m1, 3'd4};
        repeat (6) tick();
        i1.source_state = {m1, 3'd5};    // E   : p=4 starts
        tick();
        i1.source_state = {m1, 3'd6};    // E+1 : p=5 pending
        tick();
        i1.source_state = {m1, 3'd7};    // E+2 : p=6 replaces pending
        vecs++; if (i1.overrun !== 1'b0) begin
            errs++; $display("FAIL b2b_ovr_early ovr=%0b want 0", i1.overrun);
        end
        tick();                          // E+3
        vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd4 || i1.res_freq !== 28'd44
                    || i1.addr !== 3'd5 || i1.overrun !== 1'b1) begin
            errs++; $display("FAIL b2b_first rv=%0b ch=%0d f=%0d addr=%0d ovr=%0b want 1/4/44/5/1",
                             i1.res_valid, i1.res_chan, i1.res_freq, i1.addr, i1.overrun);
        end
        repeat (2) tick();               // E+5
        vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd5 || i1.res_freq !== 28'd55
                    || i1.addr !== 3'd6) begin
            errs++; $display("FAIL b2b_second rv=%0b ch=%0d f=%0d addr=%0d want 1/5/55/6",
                             i1.res_valid, i1.res_chan, i1.res_freq, i1.addr);
        end
        repeat (2) tick();               // E+7
        vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd6 || i1.res_freq !== 28'd66) begin
            errs++; $display("FAIL b2b_third rv=%0b ch=%0d f=%0d want 1/6/66",
                             i1.res_valid, i1.res_chan, i1.res_freq);
        end
        tick();
        vecs++; if (i1.res_valid !== 1'b0) begin
            errs++; $display("FAIL b2b_done rv=%0b want 0", i1.res_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        mem1[3] = 28'd77;
        m1 = m1 + 3'd1;
        i1.source_state = {m1, 3'd1};
        repeat (6) tick();
        i1.source_state = {m1, 3'd2};    // E: p=1 starts
        tick();                          // E+1: WAIT
        rst_n = 1'b0;
        #1;
        vecs++; if (i1.addr !== 3'd0 || i1.res_valid !== 1'b0 || i1.overrun !== 1'b0
                    || i1.alarm !== 8'h00 || i1.rd_data !== 31'd0) begin
            errs++; $display("FAIL rst_mid addr=%0h rv=%0b ovr=%0b alarm=%0h rd=%0h want 0",
                             i1.addr, i1.res_valid, i1.overrun, i1.alarm, i1.rd_data);
        end
        tick();
        rst_n = 1'b1;
        i1.rd_addr = 3'd3;
        tick();                          // ss reloaded
        vecs++; if (i1.rd_data !== 31'd0) begin
            errs++; $display("FAIL rst_cache rd=%0h want 0", i1.rd_data);
        end
        i1.source_state = {m1, 3'd3};    // discarded
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (i1.res_valid !== 1'b0) seen = 1'b1;
        end
        vecs++; if (seen) begin
            errs++; $display("FAIL rst_rearm saw res_valid, want none");
        end
        i1.source_state = {m1, 3'd4};    // E: p=3
        repeat (3) tick();
        vecs++; if (i1.res_valid !== 1'b1 || i1.res_chan !== 3'd3 || i1.res_freq !== 28'd77
                    || i1.alarm !== 8'h00) begin
            errs++; $display("FAIL rst_next rv=%0b ch=%0d f=%0d alarm=%0h want 1/3/77/0",
                             i1.res_valid, i1.res_chan, i1.res_freq, i1.alarm);
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_ng2();
        test_limits();
        test_alarm_clr();
        test_limit_race();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
